// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seg_scan_ctrl : double-buffered scan controller for a common-anode
//                 multi-digit 7-segment display (one anode per slot).
// Revision      : 1.0 - initial release
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              char,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] C_CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] C_BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] C_IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] C_AN_OFF = {NUM_DIGITS{1'b1}};
  localparam logic [NUM_DIGITS-1:0] C_AN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SCAN  = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          frame_end;

  logic [4*NUM_DIGITS-1:0] sh_data_q, sh_data_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_en_q, sh_en_d;
  logic [4*NUM_DIGITS-1:0] act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_en_q, act_en_d;
  logic                    pending_q, pending_d;

  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [3:0]              char_q, char_d;
  logic                    dp_q, dp_d;
  logic                    fd_q, fd_d;

  // Slot sequencer: cnt only wraps at the end of SCAN, so a slot is exactly
  // REFRESH_DIV cycles regardless of whether the digit is enabled.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    frame_end = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == C_BLANK_END) begin
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (cnt_q == C_CNT_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == C_IDX_LAST) begin
            idx_d     = '0;
            frame_end = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Buffers: the frame-end copy reads the pre-edge shadow, so a load in that
  // same cycle lands in the shadow and stays pending for the next frame.
  always_comb begin
    sh_data_d  = sh_data_q;
    sh_dp_d    = sh_dp_q;
    sh_en_d    = sh_en_q;
    act_data_d = act_data_q;
    act_dp_d   = act_dp_q;
    act_en_d   = act_en_q;
    pending_d  = pending_q;
    if (frame_end) begin
      act_data_d = sh_data_q;
      act_dp_d   = sh_dp_q;
      act_en_d   = sh_en_q;
      pending_d  = 1'b0;
    end
    if (load) begin
      sh_data_d = data_in;
      sh_dp_d   = dp_in;
      sh_en_d   = digit_en;
      pending_d = 1'b1;
    end
  end

  // Outputs are computed from next-state values so they register on the
  // same edge as the state and index they describe.
  always_comb begin
    an_d   = C_AN_OFF;
    char_d = act_data_d[{idx_d, 2'b00} +: 4];
    dp_d   = act_dp_d[idx_d];
    fd_d   = frame_end;
    if (state_d == ST_SCAN && act_en_d[idx_d]) begin
      an_d = ~(C_AN_ONE << idx_d);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_en_q    <= '0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
      pending_q  <= 1'b0;
      an_q       <= C_AN_OFF;
      char_q     <= '0;
      dp_q       <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sh_data_q  <= sh_data_d;
      sh_dp_q    <= sh_dp_d;
      sh_en_q    <= sh_en_d;
      act_data_q <= act_data_d;
      act_dp_q   <= act_dp_d;
      act_en_q   <= act_en_d;
      pending_q  <= pending_d;
      an_q       <= an_d;
      char_q     <= char_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
    end
  end

  assign an         = an_q;
  assign char       = char_q;
  assign dp         = dp_q;
  assign pending    = pending_q;
  assign frame_done = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl : scoreboard bench for seg_scan_ctrl (4 digits, 8/2 timing)
// Revision         : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

  localparam int N     = 4;
  localparam int RD    = 8;
  localparam int BL    = 2;
  localparam int FRAME = N * RD;

  logic           clk = 1'b0;
  logic           reset;
  logic           load;
  logic [4*N-1:0] data_in;
  logic [N-1:0]   dp_in;
  logic [N-1:0]   digit_en;
  logic [3:0]     char_w;
  logic           dp_w;
  logic [N-1:0]   an_w;
  logic           pending_w;
  logic           fd_w;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .BLANK_CYCLES(BL)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .char       (char_w),
    .dp         (dp_w),
    .an         (an_w),
    .pending    (pending_w),
    .frame_done (fd_w)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] an;
    logic         chk;
    logic [3:0]   ch;
    logic         dp;
    logic         pend;
    logic         fd;
  } exp_t;

  exp_t sbq[$];
  int   n_vec  = 0;
  int   n_err  = 0;
  int   k      = 0;

  // Reference model: position in the display is pure arithmetic on the number
  // of edges since reset; buffers follow the load/frame-boundary rules.
  initial begin : p_model
    logic [4*N-1:0] sh_d, act_d;
    logic [N-1:0]   sh_p, act_p, sh_e, act_e;
    logic           pend, fd;
    int             pos, dig;
    exp_t           e;
    sh_d = '0; act_d = '0; sh_p = '0; act_p = '0; sh_e = '0; act_e = '0;
    pend = 1'b0;
    forever begin
      @(posedge clk);
      fd = 1'b0;
      if (reset) begin
        k = 0;
        sh_d = '0; act_d = '0; sh_p = '0; act_p = '0; sh_e = '0; act_e = '0;
        pend = 1'b0;
      end else begin
        k = k + 1;
        if ((k % FRAME) == 0) begin
          act_d = sh_d; act_p = sh_p; act_e = sh_e;
          pend  = 1'b0;
          fd    = 1'b1;
        end
        if (load) begin
          sh_d = data_in; sh_p = dp_in; sh_e = digit_en;
          pend = 1'b1;
        end
      end
      pos = k % RD;
      dig = (k / RD) % N;
      e.an   = {N{1'b1}};
      e.chk  = reset || (pos >= BL);
      e.ch   = reset ? 4'h0 : act_d[dig*4 +: 4];
      e.dp   = reset ? 1'b0 : act_p[dig];
      e.pend = pend;
      e.fd   = fd;
      if (!reset && pos >= BL && act_e[dig]) e.an[dig] = 1'b0;
      sbq.push_back(e);
    end
  end

  initial begin : p_monitor
    exp_t e;
    logic bad;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e   = sbq.pop_front();
        bad = (an_w !== e.an) || (pending_w !== e.pend) || (fd_w !== e.fd) ||
              (e.chk && ((char_w !== e.ch) || (dp_w !== e.dp)));
        n_vec++;
        if (bad) begin
          n_err++;
          $display("FAIL scan_outputs t=%0t k=%0d: got an=%b char=%h dp=%b pend=%b fd=%b, want an=%b char=%h dp=%b pend=%b fd=%b (char/dp checked=%b)",
                   $time, k, an_w, char_w, dp_w, pending_w, fd_w,
                   e.an, e.ch, e.dp, e.pend, e.fd, e.chk);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      data_in  = 16'($urandom);
      dp_in    = 4'($urandom);
      digit_en = 4'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] en);
    load = 1'b1; data_in = d; dp_in = p; digit_en = en;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_k(input int target);
    int guard = 0;
    while ((k % FRAME) != target && guard < 2 * FRAME) begin
      idle(1);
      guard++;
    end
    if ((k % FRAME) != target) begin
      n_err++;
      $display("FAIL align_wait: got phase %0d, want %0d", k % FRAME, target);
    end
  endtask

  initial begin : p_stim
    reset = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; digit_en = '0;
    idle(3);
    reset = 1'b0;
    idle(40);                                   // blank display, frame pulses
    wait_k(5);
    do_load(16'h4321, 4'b0100, 4'hF);
    idle(2 * FRAME);
    do_load(16'($urandom), 4'($urandom), 4'b1010);
    idle(2 * FRAME);
    do_load(16'h4321, 4'b0100, 4'hF);
    wait_k(FRAME - 1);
    do_load(16'hBEEF, 4'b0000, 4'hF);           // load on the boundary cycle
    idle(3 * FRAME);
    wait_k(3);
    do_load(16'h1111, 4'b0001, 4'hF);
    idle(7);
    do_load(16'h2222, 4'b1000, 4'hF);
    idle(2 * FRAME);
    do_load(16'($urandom), 4'($urandom), 4'hF);
    wait_k(2 * RD + 4);                         // mid-SCAN of digit 2
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(FRAME + 8);
    for (int c = 0; c < 12 * FRAME; c++) begin
      if ($urandom_range(19) == 0) begin
        do_load(16'($urandom), 4'($urandom), 4'($urandom));
      end else if ($urandom_range(299) == 0) begin
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
      end else begin
        idle(1);
      end
    end
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the board's common-anode 8-digit 7-segment display.
- Cycles through the digits, drives one active-low anode at a time and presents that digit's 4-bit hex code to the existing hex-to-segment decoder.
- Also presents the digit's decimal-point request.
- Double-buffers display data so a frame never shows a mix of old and new values (no tearing). Sits between user logic and the decoder/anode pins.

Parameters:
- NUM_DIGITS, 8: number of digits scanned (2..8).
- REFRESH_DIV, 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz). Must be > BLANK_CYCLES.
- BLANK_CYCLES, 1000: anti-ghosting cycles at the start of each slot with all anodes off. Must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe; captures data_in/dp_in/digit_en into the shadow buffer
- data_in  in  4*NUM_DIGITS  hex codes; digit i = data_in[4i+3:4i]
- dp_in  in  NUM_DIGITS  decimal-point request per digit, active-high
- digit_en  in  NUM_DIGITS  per-digit enable, active-high; 0 keeps that anode off
- char  out  4  hex code of the current digit, to the decoder
- dp  out  1  decimal point for the current digit, active-high
- an  out  NUM_DIGITS  anode drives, active-low
- pending  out  1  shadow holds data not yet displayed
- frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Clocking: one clock domain. Reset is synchronous and active-high; all registers reset on the clk edge where reset=1.
- Reset values:
  - state=BLANK, idx=0, cnt=0.
  - Active and shadow buffers all zero, including en=0.
  - an=all 1s, char=0, dp=0, pending=0, frame_done=0.
- Outputs are registered and change on the same edge as the state/idx they reflect.
- FSM per slot, for digit idx:
  - BLANK: an=all 1s. Lasts BLANK_CYCLES cycles, then goes to SCAN.
  - SCAN: an[idx]=0 if active en[idx]=1, else all 1s. char=active data[idx], dp=active dp[idx]. Lasts REFRESH_DIV-BLANK_CYCLES cycles.
  - At the end of SCAN: idx wraps from NUM_DIGITS-1 to 0, else increments; state returns to BLANK.
  - char/dp are also driven during BLANK and track the upcoming idx; they are don't-care for verification while an is all 1s.
- Counter cnt: 0..REFRESH_DIV-1 per slot; BLANK while cnt<BLANK_CYCLES. Width = clog2(REFRESH_DIV).
- Slot length is exactly REFRESH_DIV cycles; frame period is NUM_DIGITS*REFRESH_DIV. Disabled digits still consume their slot, so brightness is constant.
- At most one an bit is low in any cycle.
- load:
  - When load=1: shadow <= {data_in, dp_in, digit_en}, and pending <= 1.
  - Back-to-back loads: the last one wins.
- Frame boundary (last cycle of SCAN for idx=NUM_DIGITS-1):
  - active <= shadow (value before this edge), pending <= 0, frame_done=1 for the following cycle.
  - This copy happens every frame whether or not pending is set.
  - New data first appears in the BLANK slot of digit 0.
- load in the boundary cycle: the active buffer takes the old shadow. The shadow takes the new data, and pending stays 1, so the new data shows in the next frame.
- reset asserted mid-slot or mid-frame: immediate return to reset values on that edge. Shadow data and the pending flag are discarded.

Test Plan (bench uses NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2):
1. Reset release, no load -> an=4'b1111 for 2 cycles, then all 1s for the full frame (en=0). frame_done pulses every 32 cycles.
2. load data_in=16'h4321, dp_in=4'b0100, digit_en=4'hF during the first frame:
   - pending=1 until the boundary, then 0.
   - Next frame: an sequence 1110,1101,1011,0111, each low for 6 cycles after 2 all-1s cycles.
   - char per digit = 1,2,3,4; dp=1 only while an=1011.
3. digit_en=4'b1010 -> an stays 1111 during the slots of digits 0 and 2; frame period is unchanged at 32.
4. load asserted exactly in the boundary cycle with 16'hBEEF while the shadow holds 16'h4321:
   - The next frame shows 4321 and pending stays 1.
   - The frame after shows BEEF (char F,E,E,B).
5. Two loads (16'h1111 then 16'h2222) within one frame -> only 2222 is displayed.
6. reset asserted mid-SCAN of digit 2 with pending=1 -> next cycle an=1111, pending=0. After release: 2-cycle blank, then the digit-0 slot with all digits disabled.
7. Continuous check over >= 10 frames: never more than one an bit low, and an never low during the first 2 cycles of a slot.
